// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative multiply/divide unit owning the Hi/Lo result
// registers and the divide-by-zero status bit.
//
// One operation at a time: accepted in IDLE, DATA_W iterations in CALC,
// then FIX applies the sign correction and writes Hi/Lo.
// Total latency is DATA_W+1 cycles from the accepting edge.
//
// Optional feature macro: MULDIV_SIGNED_EN
//   defined   : op 01 = signed MUL, op 11 = signed DIV (magnitude datapath
//               plus two's-complement fix-up in FIX)
//   undefined : op 01 behaves as MULU, op 11 as DIVU; no sign logic
//
// Ports
//   clk    in  clock, rising edge
//   rest   in  asynchronous active-high reset
//   start  in  request new operation (sampled in IDLE only)
//   op     in  00 MULU, 01 MUL, 10 DIVU, 11 DIV
//   src_a  in  multiplicand / dividend
//   src_b  in  multiplier / divisor
//   flush  in  synchronous abort of in-flight work (also blocks start in IDLE)
//   busy   out operation in progress
//   done   out one-cycle pulse when Hi/Lo hold a new result
//   hi     out MUL upper half / DIV remainder
//   lo     out MUL lower half / DIV quotient
//   dz     out divide-by-zero, sticky until the next accepted start
module muldiv_unit #(
    parameter  int DATA_W = 16,
    localparam int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              dz
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_cnt;
    // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
    logic [2*DATA_W-1:0] r_acc;
    // Multiplicand (multiply) or divisor (divide) magnitude.
    logic [DATA_W-1:0]   r_opb;
    logic                r_div;
    logic                r_done;
    logic                r_dz;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    logic [DATA_W-1:0]   w_mag_a;
    logic [DATA_W-1:0]   w_mag_b;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_quo;
    logic [DATA_W-1:0]   w_rem;

`ifdef MULDIV_SIGNED_EN
    logic w_sa;
    logic w_sb;
    logic r_neg_q;   // product / quotient negative
    logic r_neg_r;   // remainder negative (follows dividend)

    assign w_sa    = op[0] & src_a[DATA_W-1];
    assign w_sb    = op[0] & src_b[DATA_W-1];
    // Most-negative maps onto itself, which is the correct unsigned magnitude.
    assign w_mag_a = w_sa ? -src_a : src_a;
    assign w_mag_b = w_sb ? -src_b : src_b;
    assign w_prod  = r_neg_q ? -r_acc : r_acc;
    assign w_quo   = r_neg_q ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
    assign w_rem   = r_neg_r ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];
`else
    logic w_unused_op0;

    assign w_unused_op0 = op[0];
    assign w_mag_a = src_a;
    assign w_mag_b = src_b;
    assign w_prod  = r_acc;
    assign w_quo   = r_acc[DATA_W-1:0];
    assign w_rem   = r_acc[2*DATA_W-1:DATA_W];
`endif

    // Shift-add step, LSB-first: add multiplicand when the current multiplier
    // bit is set, then shift the whole accumulator right (carry enters the top).
    logic [DATA_W:0]     w_sum;
    logic [2*DATA_W-1:0] w_mul_nxt;

    assign w_sum     = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_nxt = {w_sum, r_acc[DATA_W-1:1]};

    // Restoring step, MSB-first: bring next dividend bit into the partial
    // remainder, subtract divisor if it fits, shift quotient bit in from the right.
    // A zero divisor always "fits", giving an all-ones quotient and rem = dividend.
    logic [DATA_W:0]     w_prem;
    logic                w_ge;
    logic [DATA_W-1:0]   w_diff;
    logic [2*DATA_W-1:0] w_div_nxt;

    assign w_prem    = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
    assign w_ge      = (w_prem >= {1'b0, r_opb});
    assign w_diff    = w_prem[DATA_W-1:0] - r_opb;
    assign w_div_nxt = {(w_ge ? w_diff : w_prem[DATA_W-1:0]), r_acc[DATA_W-2:0], w_ge};

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opb   <= '0;
            r_div   <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
`ifdef MULDIV_SIGNED_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_state <= S_CALC;
                        r_cnt   <= '0;
                        r_div   <= op[1];
                        r_dz    <= op[1] && (src_b == '0);
                        // Divide iterates over the dividend; multiply over the multiplier.
                        r_acc   <= {{DATA_W{1'b0}}, (op[1] ? w_mag_a : w_mag_b)};
                        r_opb   <= op[1] ? w_mag_b : w_mag_a;
`ifdef MULDIV_SIGNED_EN
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
`endif
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= r_div ? w_div_nxt : w_mul_nxt;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(DATA_W - 1))
                            r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    if (!flush) begin
                        r_hi   <= r_div ? w_rem : w_prod[2*DATA_W-1:DATA_W];
                        r_lo   <= r_div ? w_quo : w_prod[DATA_W-1:0];
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
    assign dz   = r_dz;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk;
    logic        rest;
    logic        start, flush;
    logic [1:0]  op;
    logic [15:0] src_a, src_b;
    logic        busy, done, dz;
    logic [15:0] hi, lo;

    logic        start32, flush32;
    logic [1:0]  op32;
    logic [31:0] src_a32, src_b32;
    logic        busy32, done32, dz32;
    logic [31:0] hi32, lo32;

    int n_chk  = 0;
    int n_fail = 0;

    muldiv_unit u_dut (
        .clk(clk), .rest(rest), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo), .dz(dz)
    );

    muldiv_unit #(.DATA_W(32)) u_dut32 (
        .clk(clk), .rest(rest), .start(start32), .op(op32), .src_a(src_a32), .src_b(src_b32),
        .flush(flush32), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .dz(dz32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference: returns {hi, lo} from plain integer arithmetic.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [15:0] a,
                                          input logic [15:0] b);
        bit     sgn;
        longint sa, sb, p, q, r;
        sgn = o[0] && SIGNED_EN;
        sa  = sgn ? longint'($signed(a)) : longint'(a);
        sb  = sgn ? longint'($signed(b)) : longint'(b);
        if (!o[1]) begin
            p = sa * sb;
            return p[31:0];
        end
        if (b == 16'd0) begin
            // Magnitude result is quotient=all ones, remainder=|dividend|;
            // signs then follow the dividend (divisor counts as positive).
            q = (sa < 0) ? -longint'(16'hFFFF) : longint'(16'hFFFF);
            r = sa;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return {r[15:0], q[15:0]};
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] e;
        int k;
        e = model(o, a, b);
        op = o; src_a = a; src_b = b; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("busy_e0", busy, 1'b1);
        chk("done_one_cycle", done, 1'b0);
        chk("dz_e0", dz, (o[1] && b == 16'd0));
        k = 0;
        while (!done && k < 40) begin
            cyc();
            k++;
            if (k == 16) chk("busy_e16", busy, 1'b1);
        end
        chk("latency", k, 17);
        chk("busy_on_done", busy, 1'b0);
        chk("hi", hi, e[31:16]);
        chk("lo", lo, e[15:0]);
    endtask

    initial begin
        logic [15:0] prev_hi, prev_lo;
        logic        saw;
        int          k;
        logic [63:0] p32;

        rest = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0; src_a = '0; src_b = '0;
        start32 = 1'b0; flush32 = 1'b0; op32 = 2'd0; src_a32 = '0; src_b32 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_hi", hi, 16'h0);
        chk("rst_lo", lo, 16'h0);
        chk("rst_dz", dz, 1'b0);
        rest = 1'b0;
        cyc();

        // Directed cases
        run_op(2'b00, 16'hFFFF, 16'hFFFF);
        chk("mulu_max_hi", hi, 16'hFFFE);
        chk("mulu_max_lo", lo, 16'h0001);
        run_op(2'b01, 16'hFFFD, 16'd5);
        chk("mul_m3x5_hi", hi, SIGNED_EN ? 16'hFFFF : 16'h0004);
        chk("mul_m3x5_lo", lo, 16'hFFF1);
        run_op(2'b10, 16'd100, 16'd7);
        chk("divu_100_7", {hi, lo}, {16'd2, 16'd14});
        run_op(2'b11, 16'hFFF9, 16'd2);
        run_op(2'b10, 16'd5, 16'd0);
        chk("dz_sticky", dz, 1'b1);
        chk("divu_by0", {hi, lo}, {16'h0005, 16'hFFFF});
        run_op(2'b10, 16'd9, 16'd3);
        chk("dz_cleared", dz, 1'b0);
        run_op(2'b11, 16'h8000, 16'hFFFF);
        run_op(2'b01, 16'h8000, 16'h8000);
        run_op(2'b11, 16'hFFFB, 16'd0);

        // Flush mid-operation, with an ignored start while busy
        prev_hi = hi; prev_lo = lo;
        op = 2'b00; src_a = 16'd3; src_b = 16'd4; start = 1'b1;
        cyc();                                   // E0
        start = 1'b0;
        saw = 1'b0;
        cyc(); saw |= done;                      // E1
        cyc(); saw |= done;                      // E2
        op = 2'b00; src_a = 16'd7; src_b = 16'd7; start = 1'b1;
        cyc(); saw |= done;                      // E3: ignored
        start = 1'b0;
        chk("ign_start_busy", busy, 1'b1);
        cyc(); saw |= done;                      // E4
        flush = 1'b1;
        cyc(); saw |= done;                      // E5: flushed
        flush = 1'b0;
        chk("flush_busy", busy, 1'b0);
        chk("flush_no_done", saw, 1'b0);
        chk("flush_hi", hi, prev_hi);
        chk("flush_lo", lo, prev_lo);
        run_op(2'b00, 16'd3, 16'd4);             // accepted at E6

        // start + flush together in IDLE: start dropped
        op = 2'b10; src_a = 16'd1; src_b = 16'd0; start = 1'b1; flush = 1'b1;
        cyc();
        start = 1'b0; flush = 1'b0;
        chk("flush_wins_busy", busy, 1'b0);
        chk("flush_wins_dz", dz, 1'b0);

        // Asynchronous reset mid-divide
        op = 2'b11; src_a = 16'hFFF9; src_b = 16'd0; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("rst_pre_dz", dz, 1'b1);
        repeat (7) cyc();
        @(posedge clk);                          // E8
        #1 rest = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_hi", hi, 16'h0);
        chk("arst_lo", lo, 16'h0);
        chk("arst_dz", dz, 1'b0);
        #3 rest = 1'b0;
        saw = 1'b0;
        repeat (20) begin cyc(); saw |= done; end
        chk("arst_no_done", saw, 1'b0);
        run_op(2'b10, 16'd100, 16'd7);

        // Randomised operations
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 7))
                0: b = 16'd0;
                1: a = 16'h8000;
                2: b = 16'hFFFF;
                3: b = 16'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(2'($urandom_range(0, 3)), a, b);
        end

        // 32-bit instance
        op32 = 2'b00; src_a32 = 32'hFFFF_FFFF; src_b32 = 32'hFFFF_FFFF; start32 = 1'b1;
        p32 = 64'(src_a32) * 64'(src_b32);
        cyc();
        start32 = 1'b0;
        k = 0;
        while (!done32 && k < 60) begin cyc(); k++; end
        chk("lat32", k, 33);
        chk("mulu32_hi", hi32, p32[63:32]);
        chk("mulu32_lo", lo32, p32[31:0]);
        chk("mulu32_hi_const", hi32, 32'hFFFF_FFFE);

        op32 = 2'b10; src_a32 = $urandom; src_b32 = 32'($urandom_range(1, 65535)); start32 = 1'b1;
        cyc();
        start32 = 1'b0;
        k = 0;
        while (!done32 && k < 60) begin cyc(); k++; end
        chk("lat32_div", k, 33);
        chk("divu32_q", lo32, src_a32 / src_b32);
        chk("divu32_r", hi32, src_a32 % src_b32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
